hazard_ctl: RTL

- Central hazard unit for the 5-stage pipeline. Consumes the E-stage hazard tuple (ra1E, ra2E, waE, resE) from the E-stage hazard register.
- Carries that tuple through its own M and W hazard registers.
- Generates stall/Eclr and all forwarding selects, and tracks the multi-cycle mult/div unit's busy window.

---
 rtl/hazard_ctl_pkg.sv | 51 +++++
 rtl/hazard_md_busy.sv | 34 +++
 rtl/hazard_ctl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_ctl_pkg.sv
// Shared encodings and helpers for the pipeline hazard unit.
package hazard_ctl_pkg;

    // Result-source encoding carried with each instruction's hazard tuple
    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;
    localparam logic [2:0] RES_MD  = 3'd4;

    // D-stage compare operand selects
    localparam logic [1:0] FWD_D_RF   = 2'd0;
    localparam logic [1:0] FWD_D_E_PC = 2'd1;
    localparam logic [1:0] FWD_D_M    = 2'd2;

    // E-stage ALU operand selects
    localparam logic [1:0] FWD_E_RF = 2'd0;
    localparam logic [1:0] FWD_E_M  = 2'd1;
    localparam logic [1:0] FWD_E_W  = 2'd2;

    // M-stage store-data select
    localparam logic FWD_M_RF = 1'b0;
    localparam logic FWD_M_W  = 1'b1;

    // Operand never read by the instruction
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Cycles until the result is available, counted from E
    function automatic logic [1:0] tnew_e(input logic [2:0] res);
        case (res)
            RES_ALU, RES_MD: tnew_e = 2'd1;
            RES_DM:          tnew_e = 2'd2;
            default:         tnew_e = 2'd0;
        endcase
    endfunction

    // Same, counted from M: only a load is still in flight there
    function automatic logic [1:0] tnew_m(input logic [2:0] res);
        tnew_m = (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

    // A stage writes r iff it has a real result, targets r, and r is not $0.
    // Encodings 5-7 are treated as no-write.
    function automatic logic writes(input logic [2:0] res, input logic [4:0] wa,
                                    input logic [4:0] r);
        logic w_real;
        w_real = (res == RES_ALU) || (res == RES_DM) || (res == RES_PC) || (res == RES_MD);
        writes = w_real && (wa == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_md_busy.sv
// Mult/div busy-window countdown; loads on an idle start, decrements to 0.
module hazard_md_busy
    import hazard_ctl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy
);

    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] r_cnt;

    // Countdown: a running count ignores new starts; stops at 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end else if (i_start) begin
            r_cnt <= i_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end
    end

    // Busy comes straight from the counter register, no input paths
    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctl.sv
// Central hazard unit: stall/bubble, all forwarding selects, mult/div busy.
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ra1D,
    input  logic [4:0] ra2D,
    input  logic [1:0] tuse_rsD,
    input  logic [1:0] tuse_rtD,
    input  logic       md_opD,
    input  logic [4:0] ra1E,
    input  logic [4:0] ra2E,
    input  logic [4:0] waE,
    input  logic [2:0] resE,
    input  logic       md_start,
    input  logic       md_is_div,
    output logic       stall,
    output logic       Eclr,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic [1:0] fwd_rsE,
    output logic [1:0] fwd_rtE,
    output logic       fwd_rtM,
    output logic       md_busy
);

    // M and W copies of the hazard tuple; they never stall, bubbles drain through
    logic [4:0] r_ra2M;
    logic [4:0] r_waM;
    logic [2:0] r_resM;
    logic [4:0] r_waW;
    logic [2:0] r_resW;

    // Advance the hazard tuple E -> M -> W every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ra2M <= '0;
            r_waM  <= '0;
            r_resM <= RES_NW;
            r_waW  <= '0;
            r_resW <= RES_NW;
        end else begin
            r_ra2M <= ra2E;
            r_waM  <= waE;
            r_resM <= resE;
            r_waW  <= r_waM;
            r_resW <= r_resM;
        end
    end

    logic w_md_busy;

    hazard_md_busy #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy (
        .clk      (clk),
        .rst      (rst),
        .i_start  (md_start),
        .i_is_div (md_is_div),
        .o_busy   (w_md_busy)
    );

    logic [1:0] w_tnewE;
    logic [1:0] w_tnewM;
    assign w_tnewE = tnew_e(resE);
    assign w_tnewM = tnew_m(r_resM);

    // D-stage producer matches
    logic w_e_rsD, w_m_rsD, w_e_rtD, w_m_rtD;
    assign w_e_rsD = writes(resE, waE, ra1D);
    assign w_m_rsD = writes(r_resM, r_waM, ra1D);
    assign w_e_rtD = writes(resE, waE, ra2D);
    assign w_m_rtD = writes(r_resM, r_waM, ra2D);

    // Stall when a producer's value arrives later than the consumer needs it;
    // tuse = 3 can never lose to a tnew of at most 2.
    logic w_stall_rs, w_stall_rt, w_stall_md, w_stall;
    assign w_stall_rs = (w_e_rsD && (w_tnewE > tuse_rsD)) || (w_m_rsD && (w_tnewM > tuse_rsD));
    assign w_stall_rt = (w_e_rtD && (w_tnewE > tuse_rtD)) || (w_m_rtD && (w_tnewM > tuse_rtD));
    assign w_stall_md = md_opD && (w_md_busy || md_start);
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

    // Forwarding candidates; only a ready value (tnew = 0) may be forwarded
    logic w_fd_rs_e, w_fd_rs_m, w_fd_rt_e, w_fd_rt_m;
    logic w_fe_rs_m, w_fe_rs_w, w_fe_rt_m, w_fe_rt_w, w_fm_rt_w;
    assign w_fd_rs_e = w_e_rsD && (resE == RES_PC);
    assign w_fd_rs_m = w_m_rsD && (w_tnewM == 2'd0);
    assign w_fd_rt_e = w_e_rtD && (resE == RES_PC);
    assign w_fd_rt_m = w_m_rtD && (w_tnewM == 2'd0);
    assign w_fe_rs_m = writes(r_resM, r_waM, ra1E) && (w_tnewM == 2'd0);
    assign w_fe_rs_w = writes(r_resW, r_waW, ra1E);
    assign w_fe_rt_m = writes(r_resM, r_waM, ra2E) && (w_tnewM == 2'd0);
    assign w_fe_rt_w = writes(r_resW, r_waW, ra2E);
    assign w_fm_rt_w = writes(r_resW, r_waW, r_ra2M);

    // Output selects, nearest stage first; forced quiet while reset is held
    // so that live E-stage inputs cannot leak through during reset.
    always_comb begin
        stall   = 1'b0;
        fwd_rsD = FWD_D_RF;
        fwd_rtD = FWD_D_RF;
        fwd_rsE = FWD_E_RF;
        fwd_rtE = FWD_E_RF;
        fwd_rtM = FWD_M_RF;
        if (rst) begin
            stall = w_stall;
            if (w_fd_rs_e)      fwd_rsD = FWD_D_E_PC;
            else if (w_fd_rs_m) fwd_rsD = FWD_D_M;
            if (w_fd_rt_e)      fwd_rtD = FWD_D_E_PC;
            else if (w_fd_rt_m) fwd_rtD = FWD_D_M;
            if (w_fe_rs_m)      fwd_rsE = FWD_E_M;
            else if (w_fe_rs_w) fwd_rsE = FWD_E_W;
            if (w_fe_rt_m)      fwd_rtE = FWD_E_M;
            else if (w_fe_rt_w) fwd_rtE = FWD_E_W;
            if (w_fm_rt_w)      fwd_rtM = FWD_M_W;
        end
    end

    assign Eclr    = stall;
    assign md_busy = w_md_busy;

endmodule
